cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional-unit requesters (2..8).
REQ-002 Parameter MAX_PRF_STREAK, default 3: maximum consecutive PRF-read wins while any FU waits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 fu_req  input  NUM_FU  per-FU broadcast request; held until granted.
REQ-006 fu_id  input  NUM_FU x 4  destination physical register per FU.
REQ-007 fu_val  input  NUM_FU x 8  result value per FU.
REQ-008 fu_grant  output  NUM_FU  one-hot-or-zero, combinational grant this cycle.
REQ-009 prf_rd_req  input  1  request to rebroadcast a PRF entry; held until granted.
REQ-010 prf_rd_id  input  4  PRF entry to rebroadcast.
REQ-011 prf_rd_grant  output  1  combinational grant for the PRF read.
REQ-012 requesting  output  1  PRF read-port enable; equals prf_rd_grant.
REQ-013 requested_id  output  4  PRF read address; prf_rd_id when requesting, else 0.
REQ-014 prf_cdb_val  input  8  PRF read data, valid combinationally in the cycle requesting=1.
REQ-015 shared_cdb_transmit  output  1  registered: broadcast valid.
REQ-016 shared_cdb_id  output  4  registered: broadcast register id.
REQ-017 shared_cdb_val  output  8  registered: broadcast value.
REQ-018 shared_cdb_write  output  1  registered: PRF marks the entry ready.
REQ-019 cdb_stall  input  1  when 1, no grant is issued and output registers hold.

Function
REQ-020 At most one grant per cycle across fu_grant and prf_rd_grant; no grant when cdb_stall=1 or no requests.
REQ-021 Arbitration is combinational from current requests and state; a granted request appears on the shared_cdb_* outputs exactly 1 cycle later.
REQ-022 PRF-read priority: prf_rd_req wins unless streak_cnt == MAX_PRF_STREAK and some fu_req is set; then the FU round-robin winner is granted.
REQ-023 streak_cnt (width ceil(log2(MAX_PRF_STREAK+1))): +1 on a PRF-read grant while any fu_req=1, saturating at MAX_PRF_STREAK; cleared on any FU grant or any cycle with no fu_req; held on stall.
REQ-024 FU round robin: search begins at rr_ptr, ascending with wrap at NUM_FU-1 to 0; first requester wins.
REQ-025 rr_ptr updates to (winner+1) mod NUM_FU only on an FU grant; otherwise holds.
REQ-026 FU grant registers: transmit=1, id=fu_id[w], val=fu_val[w], write=1 if fu_id[w]!=0, else 0.
REQ-027 PRF grant registers: transmit=1, id=prf_rd_id, val=prf_cdb_val, write=0 (rebroadcast never re-marks ready).
REQ-028 Non-stalled cycle with no grant: transmit=0, id=0, val=0, write=0.
REQ-029 Stalled cycle: all shared_cdb_* registers, rr_ptr and streak_cnt hold.
REQ-030 A requester that drops its request without a grant is removed from arbitration with no side effect.
REQ-031 Requests set in the same cycle as reset release are arbitrated starting the next cycle.

Reset
REQ-032 rst=0 at a rising edge: shared_cdb_transmit/id/val/write = 0, rr_ptr = 0, streak_cnt = 0.
REQ-033 While rst=0, all fu_grant, prf_rd_grant and requesting are 0 and requested_id is 0; reset mid-broadcast discards the pending output.

Verification
REQ-034 fu_req=4'b1111, all held, NUM_FU=4 -> grants FU0,1,2,3,0 on consecutive cycles; each result on shared_cdb 1 cycle after its grant with write=1.
REQ-035 prf_rd_req=1 (id 5, prf_cdb_val 0x3C) and fu_req[2]=1 held, MAX_PRF_STREAK=3 -> PRF granted 3 cycles, FU2 in cycle 4, then PRF; PRF broadcasts carry id 5, val 0x3C, write=0.
REQ-036 FU1 requests with fu_id=0, val 0x77 -> next cycle transmit=1, id=0, val=0x77, write=0.
REQ-037 fu_req[0]=1 with cdb_stall=1 for 3 cycles -> no grant, outputs hold prior value; stall drops -> grant in that cycle, broadcast next cycle.
REQ-038 rst=0 asserted in the cycle after an FU3 grant -> shared_cdb_transmit=0 next cycle, rr_ptr=0; after release, fu_req=4'b1010 -> FU1 granted first.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one grant per cycle between FU results and PRF
// rebroadcast reads, with a registered shared CDB output stage.
module cdb_arbiter #(
  parameter int NUM_FU         = 4,
  parameter int MAX_PRF_STREAK = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FU-1:0]     fu_req,
  input  logic [NUM_FU*4-1:0]   fu_id,
  input  logic [NUM_FU*8-1:0]   fu_val,
  output logic [NUM_FU-1:0]     fu_grant,
  input  logic                  prf_rd_req,
  input  logic [3:0]            prf_rd_id,
  output logic                  prf_rd_grant,
  output logic                  requesting,
  output logic [3:0]            requested_id,
  input  logic [7:0]            prf_cdb_val,
  output logic                  shared_cdb_transmit,
  output logic [3:0]            shared_cdb_id,
  output logic [7:0]            shared_cdb_val,
  output logic                  shared_cdb_write,
  input  logic                  cdb_stall
);

  localparam int PTR_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int STREAK_W = (MAX_PRF_STREAK > 0) ? $clog2(MAX_PRF_STREAK + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(MAX_PRF_STREAK);
  localparam logic [PTR_W-1:0]    LAST_FU     = PTR_W'(NUM_FU - 1);

  typedef struct packed {
    logic       transmit;
    logic [3:0] id;
    logic [7:0] val;
    logic       write;
  } cdb_t;

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  cdb_t                cdb_q, cdb_d;
  logic                ready_q;

  logic [3:0] fu_id_a  [NUM_FU];
  logic [7:0] fu_val_a [NUM_FU];

  logic             any_fu, streak_full, prf_wins, grant_en;
  logic             fu_found, fu_gnt, prf_gnt;
  logic [PTR_W-1:0] fu_win, cand;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_unpack
    assign fu_id_a[g]  = fu_id[g*4 +: 4];
    assign fu_val_a[g] = fu_val[g*8 +: 8];
  end

  // ready_q is low for the first cycle after reset release, so requests
  // raised alongside the release are not served until the following cycle.
  assign grant_en    = rst && ready_q && !cdb_stall;
  assign any_fu      = |fu_req;
  assign streak_full = (streak_q == STREAK_MAX);
  assign prf_wins    = prf_rd_req && !(streak_full && any_fu);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fu_found = 1'b0;
    fu_win   = '0;
    cand     = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_FU);
      if (!fu_found && fu_req[cand]) begin
        fu_found = 1'b1;
        fu_win   = cand;
      end
    end
  end

  assign prf_gnt      = grant_en && prf_wins;
  assign fu_gnt       = grant_en && !prf_wins && fu_found;
  assign fu_grant     = fu_gnt ? (NUM_FU'(1) << fu_win) : '0;
  assign prf_rd_grant = prf_gnt;
  assign requesting   = prf_gnt;
  assign requested_id = prf_gnt ? prf_rd_id : 4'd0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    streak_d = streak_q;
    cdb_d    = cdb_q;
    if (!cdb_stall) begin
      cdb_d = '0;
      if (fu_gnt) begin
        cdb_d.transmit = 1'b1;
        cdb_d.id       = fu_id_a[fu_win];
        cdb_d.val      = fu_val_a[fu_win];
        cdb_d.write    = |fu_id_a[fu_win];
        rr_ptr_d       = (fu_win == LAST_FU) ? '0 : fu_win + 1'b1;
        streak_d       = '0;
      end else if (prf_gnt) begin
        // Rebroadcasts never re-mark the entry ready.
        cdb_d.transmit = 1'b1;
        cdb_d.id       = prf_rd_id;
        cdb_d.val      = prf_cdb_val;
        cdb_d.write    = 1'b0;
        if (any_fu && !streak_full) streak_d = streak_q + 1'b1;
      end
      if (!any_fu) streak_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous
  // and clears the pending broadcast along with the arbitration state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      streak_q <= '0;
      cdb_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      streak_q <= streak_d;
      cdb_q    <= cdb_d;
      ready_q  <= 1'b1;
    end
  end

  assign shared_cdb_transmit = cdb_q.transmit;
  assign shared_cdb_id       = cdb_q.id;
  assign shared_cdb_val      = cdb_q.val;
  assign shared_cdb_write    = cdb_q.write;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, round robin, PRF streak limit,
// id-zero write suppression, stall hold and mid-broadcast reset.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fu_req;
  logic [15:0] fu_id;
  logic [31:0] fu_val;
  logic [3:0]  fu_grant;
  logic        prf_rd_req;
  logic [3:0]  prf_rd_id;
  logic        prf_rd_grant;
  logic        requesting;
  logic [3:0]  requested_id;
  logic [7:0]  prf_cdb_val;
  logic        shared_cdb_transmit;
  logic [3:0]  shared_cdb_id;
  logic [7:0]  shared_cdb_val;
  logic        shared_cdb_write;
  logic        cdb_stall;

  int passed = 0;
  int total  = 0;

  logic [13:0] cdb;
  assign cdb = {shared_cdb_transmit, shared_cdb_id, shared_cdb_val, shared_cdb_write};

  localparam logic [15:0] IDS  = 16'hBA98;
  localparam logic [31:0] VALS = 32'h13121110;
  localparam logic [13:0] CDB_IDLE = 14'd0;

  cdb_arbiter #(.NUM_FU(4), .MAX_PRF_STREAK(3)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .fu_req              (fu_req),
    .fu_id               (fu_id),
    .fu_val              (fu_val),
    .fu_grant            (fu_grant),
    .prf_rd_req          (prf_rd_req),
    .prf_rd_id           (prf_rd_id),
    .prf_rd_grant        (prf_rd_grant),
    .requesting          (requesting),
    .requested_id        (requested_id),
    .prf_cdb_val         (prf_cdb_val),
    .shared_cdb_transmit (shared_cdb_transmit),
    .shared_cdb_id       (shared_cdb_id),
    .shared_cdb_val      (shared_cdb_val),
    .shared_cdb_write    (shared_cdb_write),
    .cdb_stall           (cdb_stall)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] fu_cdb(input int i);
    logic [15:0] ids;
    logic [31:0] vals;
    ids  = IDS;
    vals = VALS;
    return {1'b1, ids[i*4 +: 4], vals[i*8 +: 8], 1'b1};
  endfunction

  task automatic test_reset();
    rst = 1'b0; fu_req = 4'b1111; fu_id = IDS; fu_val = VALS;
    prf_rd_req = 1'b1; prf_rd_id = 4'd5; prf_cdb_val = 8'h3C; cdb_stall = 1'b0;
    step(); step();
    total++;
    if (cdb !== CDB_IDLE) $display("FAIL reset_cdb: got %h expected %h", cdb, CDB_IDLE);
    else passed++;
    total++;
    if ({fu_grant, prf_rd_grant, requesting, requested_id} !== 10'd0)
      $display("FAIL reset_grants: got fu=%b prf=%b req=%b id=%h expected all 0",
               fu_grant, prf_rd_grant, requesting, requested_id);
    else passed++;
    prf_rd_req = 1'b0;
  endtask

  task automatic test_release();
    rst = 1'b1; fu_req = 4'b1111;
    #1;
    total++;
    if (fu_grant !== 4'b0000) $display("FAIL release_no_grant: got %b expected 0000", fu_grant);
    else passed++;
    step();
    total++;
    if (cdb !== CDB_IDLE) $display("FAIL release_cdb: got %h expected %h", cdb, CDB_IDLE);
    else passed++;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (fu_grant !== (4'b0001 << order[c]))
        $display("FAIL rr_grant[%0d]: got %b expected %b", c, fu_grant, 4'b0001 << order[c]);
      else passed++;
      step();
      total++;
      if (cdb !== fu_cdb(order[c]))
        $display("FAIL rr_cdb[%0d]: got %h expected %h", c, cdb, fu_cdb(order[c]));
      else passed++;
    end
    fu_req = 4'b0000;
    step();
    total++;
    if (cdb !== CDB_IDLE) $display("FAIL idle_cdb: got %h expected %h", cdb, CDB_IDLE);
    else passed++;
  endtask

  task automatic test_prf_streak();
    logic [13:0] prf_cdb;
    logic [3:0]  exp_fu;
    logic        exp_prf;
    prf_cdb = {1'b1, 4'd5, 8'h3C, 1'b0};
    prf_rd_req = 1'b1; prf_rd_id = 4'd5; prf_cdb_val = 8'h3C;
    for (int c = 0; c < 5; c++) begin
      fu_req  = (c < 4) ? 4'b0100 : 4'b0000;
      exp_fu  = (c == 3) ? 4'b0100 : 4'b0000;
      exp_prf = (c != 3);
      #1;
      total++;
      if ({fu_grant, prf_rd_grant, requesting} !== {exp_fu, exp_prf, exp_prf})
        $display("FAIL streak_grant[%0d]: got fu=%b prf=%b req=%b expected fu=%b prf=%b",
                 c, fu_grant, prf_rd_grant, requesting, exp_fu, exp_prf);
      else passed++;
      total++;
      if (requested_id !== (exp_prf ? 4'd5 : 4'd0))
        $display("FAIL streak_rd_id[%0d]: got %h expected %h", c, requested_id,
                 exp_prf ? 4'd5 : 4'd0);
      else passed++;
      step();
      total++;
      if (cdb !== (exp_prf ? prf_cdb : fu_cdb(2)))
        $display("FAIL streak_cdb[%0d]: got %h expected %h", c, cdb,
                 exp_prf ? prf_cdb : fu_cdb(2));
      else passed++;
    end
    prf_rd_req = 1'b0;
    step();
  endtask

  // rr_ptr is 3 here; the search wraps 3 -> 0 -> 1 and finds FU1.
  task automatic test_id_zero();
    fu_id = 16'hBA08; fu_val = 32'h13127710; fu_req = 4'b0010;
    #1;
    total++;
    if (fu_grant !== 4'b0010) $display("FAIL idzero_grant: got %b expected 0010", fu_grant);
    else passed++;
    step();
    total++;
    if (cdb !== {1'b1, 4'd0, 8'h77, 1'b0})
      $display("FAIL idzero_cdb: got %h expected %h", cdb, {1'b1, 4'd0, 8'h77, 1'b0});
    else passed++;
  endtask

  // Continues directly from the FU1 broadcast; rr_ptr is 2.
  task automatic test_stall();
    logic [13:0] held;
    held = {1'b1, 4'd0, 8'h77, 1'b0};
    fu_id = IDS; fu_val = VALS; fu_req = 4'b0001; cdb_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if ({fu_grant, prf_rd_grant} !== 5'd0)
        $display("FAIL stall_grant[%0d]: got fu=%b prf=%b expected none", c, fu_grant, prf_rd_grant);
      else passed++;
      step();
      total++;
      if (cdb !== held) $display("FAIL stall_hold[%0d]: got %h expected %h", c, cdb, held);
      else passed++;
    end
    cdb_stall = 1'b0;
    #1;
    total++;
    if (fu_grant !== 4'b0001) $display("FAIL unstall_grant: got %b expected 0001", fu_grant);
    else passed++;
    step();
    total++;
    if (cdb !== fu_cdb(0)) $display("FAIL unstall_cdb: got %h expected %h", cdb, fu_cdb(0));
    else passed++;
    fu_req = 4'b0000;
    step();
  endtask

  // rr_ptr is 1: FU3 wins, then reset discards its broadcast.
  task automatic test_reset_mid();
    fu_req = 4'b1000;
    #1;
    total++;
    if (fu_grant !== 4'b1000) $display("FAIL mid_fu3_grant: got %b expected 1000", fu_grant);
    else passed++;
    step();
    total++;
    if (cdb !== fu_cdb(3)) $display("FAIL mid_fu3_cdb: got %h expected %h", cdb, fu_cdb(3));
    else passed++;
    rst = 1'b0; fu_req = 4'b1010;
    #1;
    total++;
    if (fu_grant !== 4'b0000) $display("FAIL mid_rst_grant: got %b expected 0000", fu_grant);
    else passed++;
    step();
    total++;
    if (cdb !== CDB_IDLE) $display("FAIL mid_rst_cdb: got %h expected %h", cdb, CDB_IDLE);
    else passed++;
    rst = 1'b1;
    step();
    #1;
    total++;
    if (fu_grant !== 4'b0010) $display("FAIL mid_after_grant: got %b expected 0010", fu_grant);
    else passed++;
    // FU1 wins leaving rr_ptr at 2; a reset must bring it back to 0.
    step();
    rst = 1'b0; fu_req = 4'b0000;
    step();
    rst = 1'b1; fu_req = 4'b1010;
    step();
    #1;
    total++;
    if (fu_grant !== 4'b0010) $display("FAIL rr_reset_grant: got %b expected 0010", fu_grant);
    else passed++;
    step();
    total++;
    if (cdb !== fu_cdb(1)) $display("FAIL rr_reset_cdb: got %h expected %h", cdb, fu_cdb(1));
    else passed++;
    fu_req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_release();
    test_round_robin();
    test_prf_streak();
    test_id_zero();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d passed", passed, total);
    $fatal(1);
  end

endmodule
